result_streamer: RTL and testbench
==================================

Name: result_streamer

Overview:
- Consumer-side reader for the matrix-multiply controller's result bank.
- When the controller signals DONE, the block captures all N*N signed results into a local buffer in one cycle.
- It then streams the results out in row-major order over a valid/ready interface, one element per beat.
- Each element is saturated to the output width and tagged with its row/column index. It sits between the controller and the downstream sink (display/UART/host bridge).

Parameters:
- N, 3, matrix dimension; the result count is N*N.
- DATA_W, 32, width of each signed controller result.
- OUT_W, 16, width of each signed output element; must be <= DATA_W.
- IDX_W, 2, width of the row/col index; must satisfy 2**IDX_W >= N.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- done  in  1  controller DONE level; the rising edge triggers capture
- result_flat  in  N*N*DATA_W  controller results; element k at [k*DATA_W +: DATA_W], with k = row*N+col
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts the beat
- out_data  out  OUT_W  saturated signed element
- out_row  out  IDX_W  row of the current element
- out_col  out  IDX_W  column of the current element
- out_last  out  1  high on element N*N-1
- out_sat  out  1  high when the current element was clipped
- busy  out  1  high in CAPTURE or STREAM
- overrun  out  1  sticky; a DONE rise was seen while busy

Behaviour:
- Reset (rst==0 at a clock edge), regardless of state:
  - State goes to IDLE; done_q=0; the element index is cleared.
  - All outputs become 0: out_valid, out_data, out_row, out_col, out_last, out_sat, busy, overrun.
  - The buffer contents are don't-care.
- Edge detect: done_rise = done & ~done_q, and done_q <= done every cycle.
  - done_q resets to 0, so done already high on the first post-reset cycle counts as a rise.
- IDLE:
  - On done_rise, latch all N*N elements of result_flat into the buffer, set idx=0, go to CAPTURE.
  - busy=1 from the next cycle.
- CAPTURE (exactly one cycle):
  - Register element 0 onto the outputs: saturated data, row/col, last, sat.
  - Assert out_valid. Go to STREAM.
  - Latency: done_rise sampled at edge t gives out_valid=1 after edge t+1.
- STREAM:
  - A beat transfers on a clock edge with out_valid & out_ready.
  - While out_valid & ~out_ready, out_data, out_row, out_col, out_last and out_sat hold stable.
  - On a transfer of a non-last element: idx+1 is presented on the next cycle with out_valid kept high. Zero bubbles, so one beat per cycle under constant ready.
  - On a transfer with out_last=1: out_valid=0 and busy=0 next cycle, go to IDLE.
  - A done_rise in the same cycle as the last transfer is treated as overrun, not a new capture.
- Index: idx counts 0..N*N-1, with out_row=idx/N and out_col=idx%N.
  - Keep separate row/col counters, no divider. col wraps N-1→0 with row+1.
- Saturation:
  - If the element exceeds 2**(OUT_W-1)-1, output that maximum with out_sat=1.
  - If it is below -2**(OUT_W-1), output that minimum with out_sat=1.
  - Otherwise output the low OUT_W bits (sign-preserving) with out_sat=0.
  - When OUT_W==DATA_W, out_sat is always 0.
- Overrun:
  - A done_rise while in CAPTURE or STREAM sets overrun=1. The buffer is not modified and the stream continues uninterrupted.
  - overrun clears only on reset.
- The buffer is only ever written in IDLE on done_rise. A result_flat change mid-stream has no effect.
- out_ready is ignored when out_valid=0.

Decomposition:
- Shared package result_streamer_pkg holds:
  - the state enum: IDLE=2'd0, CAPTURE=2'd1, STREAM=2'd2;
  - localparam NUM_ELEMS = N*N;
  - the saturation-limit constant functions.
- Sub-module sat_narrow: a combinational DATA_W→OUT_W signed saturator with outputs data and sat.
  - Instantiate it once on the muxed buffer element.
- The top level holds the FSM, the edge detect, the counters and the output registers.

Test Plan:
- Basic stream:
  - Stimulus: results 1..9, done rises at cycle 5, out_ready=1 constantly.
  - Required: out_valid high cycles 7..15; data 1..9; (row,col) (0,0)..(2,2); out_last only on 9; busy falls at cycle 16.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1,...
  - Required: every element is delivered exactly once, in order. Outputs stay stable during ready=0 stalls. No duplicates or drops.
- Saturation:
  - Stimulus: results 40000, -40000, 32767, -32768, 0, -1, 70000, -70000, 5 with OUT_W=16.
  - Required data: 32767, -32768, 32767, -32768, 0, -1, 32767, -32768, 5.
  - Required out_sat: 1,1,0,0,0,0,1,1,0.
- Overrun:
  - Stimulus: a second done pulse with new values arrives mid-stream at element 4.
  - Required: original values continue through element 8; overrun=1 and stays 1. After IDLE, the next done rise captures the new values.
- Reset mid-operation:
  - Stimulus: rst=0 for one cycle during element 3 with ready=0.
  - Required: all outputs 0 on the next cycle, state IDLE. A subsequent done rise restarts from element 0.
- Done held high from reset release:
  - Stimulus: done=1 before and after rst goes to 1.
  - Required: exactly one capture. No re-trigger until done falls and rises again.

Source files
------------

// File: rtl/result_streamer_pkg.sv
// Shared types and constants for the result streamer.
package result_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2
    } state_e;

    // Default matrix dimension and the result count it implies.
    localparam int DEF_N     = 3;
    localparam int NUM_ELEMS = DEF_N * DEF_N;

    // Largest value representable in a signed out_w-bit field.
    function automatic longint sat_max(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed out_w-bit field.
    function automatic longint sat_min(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/result_streamer_sat.sv
// Combinational signed saturator from DATA_W down to OUT_W bits.
module sat_narrow
    import result_streamer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 16
) (
    input  logic signed [DATA_W-1:0] din,
    output logic signed [OUT_W-1:0]  data,
    output logic                     sat
);

    localparam logic signed [DATA_W-1:0] MAX_V = DATA_W'(sat_max(OUT_W));
    localparam logic signed [DATA_W-1:0] MIN_V = DATA_W'(sat_min(OUT_W));

    // Clip to the output range, otherwise pass the low bits through.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data = din[OUT_W-1:0];
        sat  = 1'b0;
        if (din > MAX_V) begin
            data = MAX_V[OUT_W-1:0];
            sat  = 1'b1;
        end else if (din < MIN_V) begin
            data = MIN_V[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/result_streamer.sv
// Captures the controller result bank on DONE and streams it row-major
// over valid/ready, saturated and tagged with row/column.
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 16,
    parameter int IDX_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic [N*N*DATA_W-1:0]    result_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [IDX_W-1:0]         out_row,
    output logic [IDX_W-1:0]         out_col,
    output logic                     out_last,
    output logic                     out_sat,
    output logic                     busy,
    output logic                     overrun
);

    localparam int NUM_E = N * N;
    localparam int CNT_W = (NUM_E > 1) ? $clog2(NUM_E) : 1;

    state_e                   state_q, state_d;
    logic                     done_q;
    logic                     done_rise;
    logic [CNT_W-1:0]         idx_q, idx_d, sel_idx;
    logic signed [DATA_W-1:0] buf_q [NUM_E];
    logic signed [DATA_W-1:0] buf_d [NUM_E];
    logic                     valid_q, valid_d;
    logic [OUT_W-1:0]         data_q, data_d;
    logic [IDX_W-1:0]         row_q, row_d, col_q, col_d;
    logic                     last_q, last_d;
    logic                     sat_q, sat_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;
    logic signed [OUT_W-1:0]  sat_data;
    logic                     sat_flag;

    assign done_rise = done & ~done_q;

    // Next element to load: 0 when starting a stream, else the one after the current.
    assign sel_idx = (state_q == STREAM && !last_q) ? idx_q + CNT_W'(1) : '0;

    sat_narrow #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_sat (
        .din  (buf_q[sel_idx]),
        .data (sat_data),
        .sat  (sat_flag)
    );

    // FSM next state, buffer load, counter advance and output register update.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        valid_d   = valid_q;
        data_d    = data_q;
        row_d     = row_q;
        col_d     = col_q;
        last_d    = last_q;
        sat_d     = sat_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (done_rise) begin
                    for (int k = 0; k < NUM_E; k++) begin
                        buf_d[k] = result_flat[k*DATA_W +: DATA_W];
                    end
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (done_rise) overrun_d = 1'b1;
                idx_d   = sel_idx;
                data_d  = sat_data;
                sat_d   = sat_flag;
                last_d  = (sel_idx == CNT_W'(NUM_E - 1));
                row_d   = '0;
                col_d   = '0;
                valid_d = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (done_rise) overrun_d = 1'b1;
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = sel_idx;
                        data_d = sat_data;
                        sat_d  = sat_flag;
                        last_d = (sel_idx == CNT_W'(NUM_E - 1));
                        if (col_q == IDX_W'(N - 1)) begin
                            col_d = '0;
                            row_d = row_q + IDX_W'(1);
                        end else begin
                            col_d = col_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            last_q    <= 1'b0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            row_q     <= row_d;
            col_q     <= col_d;
            last_q    <= last_d;
            sat_q     <= sat_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // Result buffer storage.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is deliberately not reset; it is always written before it is read.
        buf_q <= buf_d;
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;
    assign out_sat   = sat_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_streamer.sv
// Scoreboard bench for result_streamer: expected beats are queued when DONE
// is raised and compared against every presented beat.
module tb_result_streamer;
    import result_streamer_pkg::*;

    localparam int N      = DEF_N;
    localparam int DATA_W = 32;
    localparam int OUT_W  = 16;
    localparam int IDX_W  = 2;
    localparam int NE     = NUM_ELEMS;

    typedef longint vec_t [NE];
    typedef struct {
        logic [OUT_W-1:0] data;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        logic             last;
        logic             sat;
        int               idx;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 done = 1'b0;
    logic                 out_ready = 1'b0;
    logic [NE*DATA_W-1:0] result_flat = '0;
    logic                 out_valid;
    logic [OUT_W-1:0]     out_data;
    logic [IDX_W-1:0]     out_row;
    logic [IDX_W-1:0]     out_col;
    logic                 out_last;
    logic                 out_sat;
    logic                 busy;
    logic                 overrun;

    result_streamer #(.N(N), .DATA_W(DATA_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .result_flat (result_flat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .out_sat     (out_sat),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   ready_mode = 0;
    int   cyc        = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int k, input longint v);
        longint mx;
        longint mn;
        exp_t   e;
        mx     = (longint'(1) <<< (OUT_W - 1)) - 1;
        mn     = -(longint'(1) <<< (OUT_W - 1));
        e.data = OUT_W'(v);
        e.sat  = 1'b0;
        if (v > mx) begin
            e.data = OUT_W'(mx);
            e.sat  = 1'b1;
        end else if (v < mn) begin
            e.data = OUT_W'(mn);
            e.sat  = 1'b1;
        end
        e.row  = IDX_W'(k / N);
        e.col  = IDX_W'(k % N);
        e.last = (k == NE - 1);
        e.idx  = k;
        return e;
    endfunction

    task automatic set_results(input vec_t v);
        for (int k = 0; k < NE; k++) result_flat[k*DATA_W +: DATA_W] = DATA_W'(v[k]);
    endtask

    task automatic push(input vec_t v);
        for (int k = 0; k < NE; k++) sb.push_back(model(k, v[k]));
    endtask

    task automatic fire(input vec_t v);
        set_results(v);
        push(v);
        done = 1'b1;
    endtask

    // One clock: drive ready, compare any presented beat with the queue head, advance.
    task automatic tick();
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'b0;
        endcase
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", out_valid, 1'b0);
            end else begin
                check($sformatf("data[%0d]", sb[0].idx), out_data, sb[0].data);
                check($sformatf("row[%0d]",  sb[0].idx), out_row,  sb[0].row);
                check($sformatf("col[%0d]",  sb[0].idx), out_col,  sb[0].col);
                check($sformatf("last[%0d]", sb[0].idx), out_last, sb[0].last);
                check($sformatf("sat[%0d]",  sb[0].idx), out_sat,  sb[0].sat);
                if (out_ready) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            check("timeout_pending", sb.size(), 0);
            check("timeout_valid", out_valid, 1'b0);
        end
    endtask

    task automatic advance_to(input int remaining, input int budget);
        int n = 0;
        while (sb.size() > remaining && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("advance_timeout", sb.size(), remaining);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"},   out_valid, 1'b0);
        check({tag, "_data"},    out_data,  '0);
        check({tag, "_row"},     out_row,   '0);
        check({tag, "_col"},     out_col,   '0);
        check({tag, "_last"},    out_last,  1'b0);
        check({tag, "_sat"},     out_sat,   1'b0);
        check({tag, "_busy"},    busy,      1'b0);
        check({tag, "_overrun"}, overrun,   1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t w;
        int   n;

        // Reset state
        rst = 1'b0;
        ready_mode = 0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b1;
        tick();

        // Basic stream with constant ready, including capture latency
        for (int k = 0; k < NE; k++) v[k] = k + 1;
        fire(v);
        tick();
        done = 1'b0;
        check("lat_valid_capture", out_valid, 1'b0);
        check("lat_busy_capture", busy, 1'b1);
        tick();
        check("lat_valid_stream", out_valid, 1'b1);
        drain(100, n);
        check("basic_beats", n, NE);
        check("basic_busy_end", busy, 1'b0);

        // Backpressure: ready 1,0,0 repeating
        for (int k = 0; k < NE; k++) v[k] = 100 * k - 300;
        ready_mode = 1;
        fire(v);
        tick();
        done = 1'b0;
        drain(200, n);
        check("bp_queue_empty", sb.size(), 0);
        ready_mode = 0;

        // Saturation corners
        v = '{40000, -40000, 32767, -32768, 0, -1, 70000, -70000, 5};
        fire(v);
        tick();
        done = 1'b0;
        drain(100, n);
        check("sat_busy_end", busy, 1'b0);

        // Overrun: second DONE with new values at element 4
        for (int k = 0; k < NE; k++) v[k] = 11 * k + 7;
        for (int k = 0; k < NE; k++) w[k] = -1000 * k - 50000;
        fire(v);
        tick();
        done = 1'b0;
        advance_to(NE - 4, 50);
        set_results(w);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("overrun_set", overrun, 1'b1);
        drain(100, n);
        check("overrun_sticky", overrun, 1'b1);
        check("overrun_busy_end", busy, 1'b0);
        fire(w);
        tick();
        done = 1'b0;
        drain(100, n);
        check("overrun_still_set", overrun, 1'b1);

        // Reset mid-stream while stalled on element 3
        for (int k = 0; k < NE; k++) v[k] = 3 * k - 4;
        fire(v);
        tick();
        done = 1'b0;
        advance_to(NE - 3, 50);
        ready_mode = 2;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sb.delete();
        check_idle("midreset");
        ready_mode = 0;
        tick();
        check("midreset_stays_idle", out_valid, 1'b0);
        fire(v);
        tick();
        done = 1'b0;
        drain(100, n);
        check("restart_beats", n, NE + 1);

        // DONE held high across reset release: exactly one capture
        for (int k = 0; k < NE; k++) v[k] = 500 - 77 * k;
        set_results(v);
        done = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        push(v);
        tick();
        drain(100, n);
        for (int i = 0; i < 5; i++) tick();
        check("held_no_retrigger_valid", out_valid, 1'b0);
        check("held_no_retrigger_busy", busy, 1'b0);
        check("held_queue_empty", sb.size(), 0);
        done = 1'b0;
        tick();
        for (int k = 0; k < NE; k++) v[k] = 9 - k;
        fire(v);
        tick();
        done = 1'b0;
        check("held_recapture_busy", busy, 1'b1);
        drain(100, n);
        check("held_end_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
